// File: rtl/key_cmd_ctrl_if.sv
// Key command bus: UART byte strobe, frame tick in; paddle/serve/bad-key pulses out.
interface key_cmd_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_tick;
    logic [3:0] btn;
    logic       start_pulse;
    logic       bad_key;

    // Stimulus side drives the byte stream and frame ticks
    modport master (
        output rx_valid,
        output rx_data,
        output frame_tick,
        input  btn,
        input  start_pulse,
        input  bad_key
    );

    // Controller side consumes bytes/ticks and produces commands
    modport slave (
        input  rx_valid,
        input  rx_data,
        input  frame_tick,
        output btn,
        output start_pulse,
        output bad_key
    );
endinterface

// File: rtl/key_cmd_ctrl.sv
// Keyboard-to-paddle command controller: decodes UART key bytes into held
// paddle commands (one FSM + hold counter per player), serve and bad-key pulses.
module key_cmd_ctrl #(
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic          clk,
    input  logic          reset,
    key_cmd_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(HOLD_FRAMES + 1);
    localparam int unsigned NP = 2;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_FRAMES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t        state_q [NP];
    state_t        state_n [NP];
    logic [CW-1:0] cnt_q   [NP];
    logic [CW-1:0] cnt_n   [NP];

    logic [NP-1:0] key_up;
    logic [NP-1:0] key_dn;
    logic          key_serve;
    logic          key_rel;
    logic          key_bad;

    logic [3:0]    btn_q;
    logic          start_q;
    logic          bad_q;

    // Case-insensitive raw-ASCII key decode, qualified by rx_valid
    always_comb begin
        key_up    = '0;
        key_dn    = '0;
        key_serve = 1'b0;
        key_rel   = 1'b0;
        key_bad   = 1'b0;
        if (bus.rx_valid) begin
            case (bus.rx_data)
                8'h71, 8'h51: key_up[0] = 1'b1;
                8'h61, 8'h41: key_dn[0] = 1'b1;
                8'h6F, 8'h4F: key_up[1] = 1'b1;
                8'h6B, 8'h4B: key_dn[1] = 1'b1;
                8'h20:        key_serve = 1'b1;
                8'h78, 8'h58: key_rel   = 1'b1;
                default:      key_bad   = 1'b1;
            endcase
        end
    end

    // Per-player next state: release-all, then key load, then tick countdown
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            state_n[p] = state_q[p];
            cnt_n[p]   = cnt_q[p];
            if (key_rel) begin
                state_n[p] = IDLE;
                cnt_n[p]   = '0;
            end else if (key_up[p]) begin
                state_n[p] = UP;
                cnt_n[p]   = HOLD_LOAD;
            end else if (key_dn[p]) begin
                state_n[p] = DOWN;
                cnt_n[p]   = HOLD_LOAD;
            end else if (bus.frame_tick && (state_q[p] != IDLE)) begin
                if (cnt_q[p] <= CNT_ONE) begin
                    state_n[p] = IDLE;
                    cnt_n[p]   = '0;
                end else begin
                    cnt_n[p]   = cnt_q[p] - CNT_ONE;
                end
            end
        end
    end

    // FSM state and hold counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                state_q[p] <= IDLE;
                cnt_q[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                state_q[p] <= state_n[p];
                cnt_q[p]   <= cnt_n[p];
            end
        end
    end

    // Registered outputs, updated on the same edge as the FSMs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q   <= 4'b0000;
            start_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            btn_q   <= {state_n[1] == DOWN, state_n[1] == UP,
                        state_n[0] == DOWN, state_n[0] == UP};
            start_q <= (|key_up) | (|key_dn) | key_serve;
            bad_q   <= key_bad;
        end
    end

    assign bus.btn         = btn_q;
    assign bus.start_pulse = start_q;
    assign bus.bad_key     = bad_q;

endmodule

// File: doc/key_cmd_ctrl.md
KEY_CMD_CTRL -- requirements
Module: key_cmd_ctrl

Interface
REQ-001 Parameter HOLD_FRAMES, default 8, is the number of frame ticks a paddle command stays asserted after one key byte; the legal range is 1..255.
REQ-002 clk  input  1  100 MHz system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous active-low reset (asserted when 0).
REQ-004 rx_valid  input  1  one-cycle pulse in the clk domain marking a received UART byte.
REQ-005 rx_data  input  8  received byte; sampled only when rx_valid=1.
REQ-006 frame_tick  input  1  one-cycle pulse at each screen refresh (x=0, y=0).
REQ-007 btn  output  4  paddle commands: bit0 P1 up, bit1 P1 down, bit2 P2 up, bit3 P2 down.
REQ-008 start_pulse  output  1  one-cycle pulse requesting game start or serve.
REQ-009 bad_key  output  1  one-cycle pulse when a received byte is not recognised.

Function
REQ-010 Key decode uses raw ASCII with no offset correction, and matching SHALL be case-insensitive:
- q/Q (0x71/0x51): P1 up.
- a/A (0x61/0x41): P1 down.
- o/O (0x6F/0x4F): P2 up.
- k/K (0x6B/0x4B): P2 down.
- space (0x20): serve.
- x/X (0x78/0x58): release all.
- Any other byte: unrecognised.
REQ-011 Each player SHALL have an independent FSM with states IDLE, UP and DOWN, plus a hold counter of width clog2(HOLD_FRAMES+1).
REQ-012 An up key SHALL move that player's FSM from any state to UP and load its counter with HOLD_FRAMES; a down key does the same for DOWN.
REQ-013 Repeating the same key while already in UP or DOWN SHALL reload the counter to HOLD_FRAMES without leaving the state.
REQ-014 An opposite key SHALL switch directly between UP and DOWN with a reload; up and down bits for one player are never high together.
REQ-015 In UP or DOWN, each frame_tick SHALL decrement the counter; when a tick decrements it from 1 to 0, the FSM returns to IDLE in that same clock edge.
REQ-016 When rx_valid with a key for a player and frame_tick coincide, the load SHALL win: the counter equals HOLD_FRAMES afterwards and no decrement is applied.
REQ-017 A key for one player SHALL never alter the other player's FSM or counter.
REQ-018 btn SHALL be a registered decode of the FSM states: bit0=(P1==UP), bit1=(P1==DOWN), bit2=(P2==UP), bit3=(P2==DOWN).
REQ-019 btn SHALL rise on the first clock edge after the edge that samples rx_valid (latency 1 cycle).
REQ-020 Release-all SHALL force both FSMs to IDLE and both counters to 0 on the sampling edge.
REQ-021 start_pulse SHALL be high for exactly one cycle, on the cycle after rx_valid, for any byte among q, a, o, k (either case) and space.
REQ-022 start_pulse SHALL NOT be asserted for release-all or for unrecognised bytes.
REQ-023 bad_key SHALL be high for exactly one cycle, on the cycle after rx_valid, for an unrecognised byte; such a byte changes no other state.
REQ-024 rx_data SHALL be ignored whenever rx_valid=0.
REQ-025 Back-to-back rx_valid on consecutive cycles SHALL each be processed in arrival order, with no loss.
REQ-026 frame_tick while both FSMs are IDLE SHALL have no effect; the counters never underflow.

Reset
REQ-027 While reset=0, both FSMs SHALL be IDLE, both counters 0, btn=4'b0000, start_pulse=0 and bad_key=0, independent of clk.
REQ-028 If reset asserts mid-hold, the FSMs and counters SHALL clear immediately.
REQ-029 After reset deasserts, the first rx_valid SHALL be processed normally.

Verification
REQ-030 Scenario 1: rx 0x71, then 8 frame_ticks -> btn=0001 from cycle+1; start_pulse for 1 cycle; btn=0000 right after the 8th tick.
REQ-031 Scenario 2: rx 0x61 then 0x51 on consecutive cycles -> btn goes 0010 then 0001; never 0011.
REQ-032 Scenario 3: rx 0x6F then 0x6B on the same cycles as frame_ticks -> counter stays at 8 after each; btn[3:2] goes 01 then 10; btn[1:0] stays 00.
REQ-033 Scenario 4: rx 0x4B (P2 down), then 0x20, then 0x78 -> btn=1000; start_pulse after both 0x4B and 0x20; btn=0000 after 0x78; no start_pulse for 0x78.
REQ-034 Scenario 5: rx 0x7A -> bad_key for 1 cycle; btn and start_pulse unchanged.
REQ-035 Scenario 6: assert reset=0 mid-hold with btn=0100 -> btn=0000 before the next clk edge; after release, rx 0x71 -> btn=0001.
